// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared state type, header layout and address helpers for the boot loader
package boot_loader_pkg;

  typedef enum logic [3:0] {
    IDLE, HDR, LOAD_I, LOAD_D_LO, LOAD_D_HI, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE
  } bl_state_t;

  localparam int ICOUNT_LSB  = 0;
  localparam int DCOUNT_LSB  = 16;
  localparam int HDR_FIELD_W = 16;
  localparam int IMEM_STRIDE = 4;
  localparam int DMEM_STRIDE = 8;

  function automatic logic [63:0] byte_addr(input logic [15:0] word_idx, input int stride);
    return {48'b0, word_idx} * 64'(stride);
  endfunction

endpackage

// File: rtl/dump_stream_reg.sv
// rtl/dump_stream_reg.sv - 64-bit dump output holding register with valid/ready handshake
module dump_stream_reg (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        cap,
  input  logic [63:0] cap_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data
);

  // m_data only changes on a capture, so it stays stable through backpressure.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (cap) begin
      m_valid <= 1'b1;
      m_data  <= cap_data;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - loads instruction/data images into the cpu, runs it, then dumps data memory
module boot_loader_ctrl
  import boot_loader_pkg::*;
#(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_data,
  output logic             cpu_enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IDX_W = ((IMEM_ADDR_W > DMEM_ADDR_W) ? IMEM_ADDR_W : DMEM_ADDR_W) + 1;
  localparam logic [HDR_FIELD_W:0] I_DEPTH = (HDR_FIELD_W+1)'(1 << IMEM_ADDR_W);
  localparam logic [HDR_FIELD_W:0] D_DEPTH = (HDR_FIELD_W+1)'(1 << DMEM_ADDR_W);

  bl_state_t        state;
  logic [IDX_W-1:0] icount, dcount, idx;
  logic [31:0]      lo_word;
  logic [CNT_W-1:0] run_lat, run_cnt;
  logic [HDR_FIELD_W-1:0] hdr_icount, hdr_dcount;
  logic             last_i, last_d;

  assign hdr_icount = s_data[ICOUNT_LSB +: HDR_FIELD_W];
  assign hdr_dcount = s_data[DCOUNT_LSB +: HDR_FIELD_W];
  assign last_i     = (idx == icount - IDX_W'(1));
  assign last_d     = (idx == dcount - IDX_W'(1));

  assign s_ready = (state == HDR) || (state == LOAD_I) || (state == LOAD_D_LO) || (state == LOAD_D_HI);
  assign busy    = (state != IDLE) && (state != DONE);
  assign done    = (state == DONE);
  assign ren_ext = 1'b0;

  dump_stream_reg u_dump (
    .clk      (clk),
    .arst_n   (arst_n),
    .cap      (state == DUMP_CAP),
    .cap_data (rdata_ext_2),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      icount      <= '0;
      dcount      <= '0;
      idx         <= '0;
      lo_word     <= '0;
      run_lat     <= '0;
      run_cnt     <= '0;
      err         <= 1'b0;
      cpu_enable  <= 1'b0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      ren_ext_2 <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= HDR;
            err     <= 1'b0;
            run_lat <= run_cycles;
            run_cnt <= '0;
            idx     <= '0;
          end
        end
        HDR: begin
          if (s_valid) begin
            icount <= IDX_W'(hdr_icount);
            dcount <= IDX_W'(hdr_dcount);
            if ({1'b0, hdr_icount} > I_DEPTH || {1'b0, hdr_dcount} > D_DEPTH) begin
              err   <= 1'b1;
              state <= DONE;
            end else if (hdr_icount != '0) state <= LOAD_I;
            else if (hdr_dcount != '0)     state <= LOAD_D_LO;
            else                           state <= RUN;
          end
        end
        LOAD_I: begin
          if (s_valid) begin
            wen_ext   <= 1'b1;
            addr_ext  <= byte_addr(16'(idx), IMEM_STRIDE);
            wdata_ext <= s_data;
            if (last_i) begin
              idx   <= '0;
              state <= (dcount != '0) ? LOAD_D_LO : RUN;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        LOAD_D_LO: begin
          if (s_valid) begin
            lo_word <= s_data;
            state   <= LOAD_D_HI;
          end
        end
        LOAD_D_HI: begin
          if (s_valid) begin
            wen_ext_2   <= 1'b1;
            addr_ext_2  <= byte_addr(16'(idx), DMEM_STRIDE);
            wdata_ext_2 <= {s_data, lo_word};
            if (last_d) begin
              idx   <= '0;
              state <= RUN;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= LOAD_D_LO;
            end
          end
        end
        // The first RUN cycle leaves enable low so a trailing load strobe never overlaps it.
        RUN: begin
          if (run_cnt == run_lat) begin
            cpu_enable <= 1'b0;
            if (dcount != '0) begin
              ren_ext_2  <= 1'b1;
              addr_ext_2 <= byte_addr(16'(idx), DMEM_STRIDE);
              state      <= DUMP_RD;
            end else begin
              state <= DONE;
            end
          end else begin
            cpu_enable <= 1'b1;
            run_cnt    <= run_cnt + CNT_W'(1);
          end
        end
        DUMP_RD:  state <= DUMP_CAP;
        DUMP_CAP: state <= DUMP_OUT;
        DUMP_OUT: begin
          if (m_valid && m_ready) begin
            if (last_d) begin
              state <= DONE;
            end else begin
              idx        <= idx + IDX_W'(1);
              ren_ext_2  <= 1'b1;
              addr_ext_2 <= byte_addr(16'(idx + IDX_W'(1)), DMEM_STRIDE);
              state      <= DUMP_RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb/tb_boot_loader_ctrl.sv - scoreboard bench for boot_loader_ctrl with a behavioural data memory
module tb_boot_loader_ctrl;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] run_cycles = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [63:0] m_data;
  logic        cpu_enable;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext;
  logic [63:0] rdata_ext_2 = '0;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;
  logic [95:0]  exp_iw[$];
  logic [127:0] exp_dw[$];
  logic [63:0]  exp_dump[$];
  logic [63:0]  dmem [0:1023];
  int   en_total = 0;
  int   wr_total = 0;
  bit   bp = 1'b0;
  bit   stub_on = 1'b0;
  bit   rd_pend = 1'b0;
  logic [63:0] rd_addr = '0;

  always #5 clk = ~clk;

  boot_loader_ctrl #(.IMEM_ADDR_W(9), .DMEM_ADDR_W(10), .CNT_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .run_cycles(run_cycles),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Negedge observer: strobe rules, write/dump scoreboards, and a stand-in for the cpu's store.
  task automatic monitor_loop();
    logic [95:0]  ei;
    logic [127:0] ed;
    logic [63:0]  hold_data;
    bit           hold;
    int           nstb;
    hold = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("m_hold_valid", 64'(m_valid), 64'd1);
        check("m_hold_data", m_data, hold_data);
      end
      hold = m_valid && !m_ready;
      hold_data = m_data;
      nstb = int'(wen_ext) + int'(wen_ext_2) + int'(ren_ext_2);
      if (nstb != 0 || cpu_enable || ren_ext)
        check("strobe_onehot", 64'((nstb > 1) || (cpu_enable && nstb != 0) || ren_ext), 64'd0);
      if (cpu_enable) begin
        en_total++;
        if (stub_on) dmem[0] = 64'd5;
      end
      if (wen_ext) begin
        wr_total++;
        if (exp_iw.size() == 0) check("iw_unexpected", 64'd1, 64'd0);
        else begin
          ei = exp_iw.pop_front();
          check("iw_addr", addr_ext, ei[95:32]);
          check("iw_data", 64'(wdata_ext), 64'(ei[31:0]));
        end
      end
      if (wen_ext_2) begin
        wr_total++;
        dmem[addr_ext_2[12:3]] = wdata_ext_2;
        if (exp_dw.size() == 0) check("dw_unexpected", 64'd1, 64'd0);
        else begin
          ed = exp_dw.pop_front();
          check("dw_addr", addr_ext_2, ed[127:64]);
          check("dw_data", wdata_ext_2, ed[63:0]);
        end
      end
      if (ren_ext_2) begin
        rd_pend = 1'b1;
        rd_addr = addr_ext_2;
      end
      if (m_valid && m_ready) begin
        if (exp_dump.size() == 0) check("dump_unexpected", 64'd1, 64'd0);
        else check("dump_data", m_data, exp_dump.pop_front());
      end
    end
  endtask

  task automatic bg_loop();
    forever begin
      tick();
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_pend) begin
        rdata_ext_2 = dmem[rd_addr[12:3]];
        rd_pend = 1'b0;
      end
    end
  endtask

  task automatic pulse_start(input logic [31:0] rc);
    run_cycles = rc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) tick();
    s_valid = 1'b1;
    s_data = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        tick();
        break;
      end
      tick();
      n++;
      if (n > 100) begin
        check("beat_timeout", 64'd0, 64'd1);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic run_seq(input int ic, input int dc, input int rc, input bit gaps,
                         input bit stub, input bit start_in_run);
    logic [31:0] w, lo, hi;
    int e0, w0, n;
    bit pulsed;
    stub_on = stub;
    e0 = en_total;
    w0 = wr_total;
    pulsed = 1'b0;
    pulse_start(rc);
    send_beat({16'(dc), 16'(ic)}, gaps);
    for (int k = 0; k < ic; k++) begin
      w = stub ? ((k == 0) ? 32'h0050_0093 : 32'h0010_3023) : $urandom;
      exp_iw.push_back({64'(4 * k), w});
      send_beat(w, gaps);
    end
    for (int j = 0; j < dc; j++) begin
      lo = $urandom;
      hi = $urandom;
      exp_dw.push_back({64'(8 * j), hi, lo});
      exp_dump.push_back((stub && j == 0) ? 64'd5 : {hi, lo});
      send_beat(lo, gaps);
      send_beat(hi, gaps);
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (start_in_run && cpu_enable && !pulsed && (en_total - e0) >= 5) begin
        pulsed = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      n++;
      if (n > 5000) begin
        check("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
    check("run_enable_cycles", 64'(en_total - e0), 64'(rc));
    check("write_pulses", 64'(wr_total - w0), 64'(ic + dc));
    check("queues_drained", 64'(exp_iw.size() + exp_dw.size() + exp_dump.size()), 64'd0);
    check("seq_done_flags", {61'd0, done, busy, err}, 64'b100);
    check("seq_s_ready", 64'(s_ready), 64'd0);
    stub_on = 1'b0;
  endtask

  task automatic hdr_error(input logic [31:0] hdr);
    int w0;
    w0 = wr_total;
    pulse_start(32'd7);
    send_beat(hdr, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    check("hdr_err_flags", {61'd0, done, busy, err}, 64'b101);
    check("hdr_err_no_write", 64'(wr_total - w0), 64'd0);
    check("hdr_err_no_enable", 64'(cpu_enable), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = '0;
    fork
      monitor_loop();
      bg_loop();
    join_none
    repeat (2) @(negedge clk);
    check("reset_flags", {58'd0, s_ready, busy, done, err, m_valid, cpu_enable}, 64'd0);
    check("reset_strobes", {61'd0, wen_ext, wen_ext_2, ren_ext_2}, 64'd0);
    check("reset_addr", addr_ext | addr_ext_2 | wdata_ext_2 | m_data, 64'd0);
    tick();
    arst_n = 1'b1;
    repeat (2) tick();

    run_seq(3, 2, 0, 1'b0, 1'b0, 1'b0);
    run_seq(2, 1, 20, 1'b0, 1'b1, 1'b0);
    hdr_error(32'h0000_0201);
    hdr_error(32'h0401_0000);
    run_seq(0, 2, 0, 1'b0, 1'b0, 1'b0);
    run_seq(2, 0, 4, 1'b0, 1'b0, 1'b0);
    bp = 1'b1;
    run_seq(5, 6, 3, 1'b1, 1'b0, 1'b0);
    bp = 1'b0;
    run_seq(512, 1, 1, 1'b0, 1'b0, 1'b0);

    // Abort mid-LOAD_I while the write pulse for the second beat is on the bus.
    pulse_start(32'd0);
    send_beat({16'd1, 16'd4}, 1'b0);
    exp_iw.push_back({64'd0, 32'h1111_0000});
    send_beat(32'h1111_0000, 1'b0);
    exp_iw.push_back({64'd4, 32'h2222_0004});
    send_beat(32'h2222_0004, 1'b0);
    #1;
    arst_n = 1'b0;
    #1;
    check("arst_strobes", {61'd0, wen_ext, wen_ext_2, ren_ext_2}, 64'd0);
    check("arst_flags", {59'd0, s_ready, busy, done, err, cpu_enable}, 64'd0);
    check("arst_addr", addr_ext | 64'(wdata_ext), 64'd0);
    exp_iw.delete();
    exp_dw.delete();
    exp_dump.delete();
    tick();
    arst_n = 1'b1;
    tick();
    run_seq(4, 1, 2, 1'b1, 1'b0, 1'b0);

    run_seq(1, 1, 12, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
